// File: rtl/game_pkg.sv
// Shared constants and types for the game screens: letter encoding, glyph geometry
// and the name-entry state enumeration.
package game_pkg;

  localparam int unsigned LETTER_W      = 5;
  localparam int unsigned ALPHABET_SIZE = 26;
  localparam int unsigned GLYPH_COLS    = 5;
  localparam int unsigned GLYPH_ROWS    = 7;
  localparam logic [11:0] COLOR_WHITE   = 12'hfff;

  typedef logic [LETTER_W-1:0] letter_t;

  typedef enum logic [1:0] {
    IDLE,
    EDIT,
    DONE
  } entry_state_t;

endpackage

// File: rtl/name_entry_renderer_if.sv
// Bundle of button, sync-counter, font-ROM and pixel signals around name_entry_renderer.
// Signal prefixes are from the renderer's point of view (slave modport).
interface name_entry_renderer_if #(
  parameter int unsigned NUM_CHARS = 3
);
  import game_pkg::*;

  logic                         i_enable;
  logic                         i_btn_left;
  logic                         i_btn_right;
  logic                         i_btn_up;
  logic                         i_btn_down;
  logic                         i_btn_confirm;
  logic                         i_frame_start;
  logic [9:0]                   i_h_cnt;
  logic [9:0]                   i_v_cnt;
  logic [5:0]                   o_font_addr;
  logic [2:0]                   o_font_h;
  logic [2:0]                   o_font_v;
  logic [11:0]                  i_font_pixel;
  logic [LETTER_W*NUM_CHARS-1:0] o_name_out;
  logic                         o_name_done;
  logic [11:0]                  o_pixel_out;
  logic                         o_valid;

  modport master (
    output i_enable, i_btn_left, i_btn_right, i_btn_up, i_btn_down, i_btn_confirm,
    output i_frame_start, i_h_cnt, i_v_cnt, i_font_pixel,
    input  o_font_addr, o_font_h, o_font_v, o_name_out, o_name_done, o_pixel_out, o_valid
  );

  modport slave (
    input  i_enable, i_btn_left, i_btn_right, i_btn_up, i_btn_down, i_btn_confirm,
    input  i_frame_start, i_h_cnt, i_v_cnt, i_font_pixel,
    output o_font_addr, o_font_h, o_font_v, o_name_out, o_name_done, o_pixel_out, o_valid
  );

endinterface

// File: rtl/name_edit_fsm.sv
// Name-entry editing state: IDLE/EDIT/DONE FSM, cursor, letters and cursor blink phase.
// Blinking is built only when NAME_ENTRY_BLINK_EN is defined; otherwise the phase is stuck at 1.
module name_edit_fsm
  import game_pkg::*;
#(
  parameter int unsigned NUM_CHARS    = 3,
  parameter int unsigned BLINK_FRAMES = 16,
  localparam int unsigned CURSOR_W    = $clog2(NUM_CHARS + 1)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          i_enable,
  input  logic                          i_btn_left,
  input  logic                          i_btn_right,
  input  logic                          i_btn_up,
  input  logic                          i_btn_down,
  input  logic                          i_btn_confirm,
  input  logic                          i_frame_start,
  output logic [CURSOR_W-1:0]           o_cursor,
  output logic [LETTER_W*NUM_CHARS-1:0] o_name,
  output entry_state_t                  o_state,
  output logic                          o_blink,
  output logic                          o_name_done
);

  localparam logic [CURSOR_W-1:0] LAST       = CURSOR_W'(NUM_CHARS);
  localparam letter_t             LETTER_MAX = LETTER_W'(ALPHABET_SIZE - 1);

  entry_state_t        r_state;
  logic [CURSOR_W-1:0] r_cursor;
  letter_t             r_letters [NUM_CHARS];
  logic                r_name_done;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_cursor    <= '0;
      r_name_done <= 1'b0;
      for (int i = 0; i < NUM_CHARS; i++) r_letters[i] <= '0;
    end else if (!i_enable) begin
      r_state     <= IDLE;
      r_name_done <= 1'b0;
    end else begin
      case (r_state)
        IDLE: r_state <= EDIT;
        EDIT: begin
          if (i_btn_confirm) begin
            if (r_cursor == LAST) begin
              r_state     <= DONE;
              r_name_done <= 1'b1;
            end else begin
              r_cursor <= r_cursor + 1'b1;
            end
          end else if (i_btn_left) begin
            if (r_cursor != '0) r_cursor <= r_cursor - 1'b1;
          end else if (i_btn_right) begin
            if (r_cursor != LAST) r_cursor <= r_cursor + 1'b1;
          end else if (i_btn_up || i_btn_down) begin
            // No letter matches when the cursor sits on the "done" slot.
            for (int i = 0; i < NUM_CHARS; i++) begin
              if (r_cursor == CURSOR_W'(i)) begin
                if (i_btn_up) begin
                  r_letters[i] <= (r_letters[i] == LETTER_MAX) ? '0 : r_letters[i] + 1'b1;
                end else begin
                  r_letters[i] <= (r_letters[i] == '0) ? LETTER_MAX : r_letters[i] - 1'b1;
                end
              end
            end
          end
        end
        DONE:    r_state <= DONE;
        default: r_state <= IDLE;
      endcase
    end
  end

`ifdef NAME_ENTRY_BLINK_EN
  localparam int unsigned BLINK_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic [BLINK_W-1:0] r_blink_cnt;
  logic               r_blink;

  // Held at its start values outside EDIT so every entry begins with the box visible.
  always_ff @(posedge clk) begin
    if (!rst_n || (r_state != EDIT)) begin
      r_blink_cnt <= '0;
      r_blink     <= 1'b1;
    end else if (i_frame_start) begin
      if (r_blink_cnt == BLINK_W'(BLINK_FRAMES - 1)) begin
        r_blink_cnt <= '0;
        r_blink     <= ~r_blink;
      end else begin
        r_blink_cnt <= r_blink_cnt + 1'b1;
      end
    end
  end

  assign o_blink = r_blink;
`else
  logic w_unused_blink;
  assign w_unused_blink = i_frame_start | (BLINK_FRAMES == 0);
  assign o_blink        = 1'b1;
`endif

  always_comb begin
    o_name = '0;
    for (int i = 0; i < NUM_CHARS; i++) begin
      o_name[LETTER_W*(NUM_CHARS-i)-1 -: LETTER_W] = r_letters[i];
    end
  end

  assign o_cursor    = r_cursor;
  assign o_state     = r_state;
  assign o_name_done = r_name_done;

endmodule

// File: rtl/name_entry_renderer.sv
// Name-entry screen: editing FSM plus a 2-stage render pipeline (decode -> font ROM -> pixel).
// NAME_ENTRY_BLINK_EN enables cursor-box blinking on frame_start.
module name_entry_renderer
  import game_pkg::*;
#(
  parameter int unsigned NUM_CHARS    = 3,
  parameter int unsigned SCALE_SHIFT  = 4,
  parameter int unsigned NAME_X0      = 190,
  parameter int unsigned NAME_Y0      = 38,
  parameter int unsigned CHAR_PITCH   = 90,
  parameter int unsigned BORDER       = 10,
  parameter int unsigned BLINK_FRAMES = 16,
  parameter int unsigned LETTER_BASE  = 10
) (
  input logic                 clk,
  input logic                 rst_n,
  name_entry_renderer_if.slave bus
);

  localparam int unsigned         CURSOR_W = $clog2(NUM_CHARS + 1);
  localparam logic [CURSOR_W-1:0] LAST     = CURSOR_W'(NUM_CHARS);
  localparam logic [10:0]         GLYPH_W  = 11'(GLYPH_COLS << SCALE_SHIFT);
  localparam logic [10:0]         GLYPH_H  = 11'(GLYPH_ROWS << SCALE_SHIFT);
  localparam logic [10:0]         X0       = 11'(NAME_X0);
  localparam logic [10:0]         Y0       = 11'(NAME_Y0);
  localparam logic [10:0]         PITCH    = 11'(CHAR_PITCH);
  localparam logic [10:0]         BRD      = 11'(BORDER);

  logic [CURSOR_W-1:0]           w_cursor;
  logic [LETTER_W*NUM_CHARS-1:0] w_name;
  entry_state_t                  w_state;
  logic                          w_blink;
  logic                          w_name_done;

  name_edit_fsm #(
    .NUM_CHARS    (NUM_CHARS),
    .BLINK_FRAMES (BLINK_FRAMES)
  ) u_fsm (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_enable      (bus.i_enable),
    .i_btn_left    (bus.i_btn_left),
    .i_btn_right   (bus.i_btn_right),
    .i_btn_up      (bus.i_btn_up),
    .i_btn_down    (bus.i_btn_down),
    .i_btn_confirm (bus.i_btn_confirm),
    .i_frame_start (bus.i_frame_start),
    .o_cursor      (w_cursor),
    .o_name        (w_name),
    .o_state       (w_state),
    .o_blink       (w_blink),
    .o_name_done   (w_name_done)
  );

  logic [10:0]         w_x, w_y, w_dx, w_dy;
  logic                w_in_row, w_glyph_hit;
  letter_t             w_code;
  logic [CURSOR_W-1:0] w_first_idx, w_last_idx;
  logic [10:0]         w_first_x, w_last_x;
  logic                w_in_outer, w_in_inner;
  logic                w_vis_glyph, w_vis_border;

  // Stage 1 decode; all geometry in 11 bits so NAME_X0 + i*CHAR_PITCH cannot wrap.
  always_comb begin
    w_x         = {1'b0, bus.i_h_cnt};
    w_y         = {1'b0, bus.i_v_cnt};
    w_in_row    = (w_y >= Y0) && (w_y < Y0 + GLYPH_H);
    w_dy        = w_y - Y0;
    w_glyph_hit = 1'b0;
    w_dx        = '0;
    w_code      = '0;
    for (int i = 0; i < NUM_CHARS; i++) begin
      if (w_in_row && (w_x >= X0 + 11'(i) * PITCH) && (w_x < X0 + 11'(i) * PITCH + GLYPH_W)) begin
        w_glyph_hit = 1'b1;
        w_dx        = w_x - (X0 + 11'(i) * PITCH);
        w_code      = w_name[LETTER_W*(NUM_CHARS-i)-1 -: LETTER_W];
      end
    end

    // On the "done" slot the box spans from the first to the last glyph.
    w_first_idx = (w_cursor == LAST) ? '0 : w_cursor;
    w_last_idx  = (w_cursor == LAST) ? LAST - 1'b1 : w_cursor;
    w_first_x   = X0 + 11'(w_first_idx) * PITCH;
    w_last_x    = X0 + 11'(w_last_idx) * PITCH;
    w_in_outer  = (w_x >= w_first_x - BRD) && (w_x < w_last_x + GLYPH_W + BRD) &&
                  (w_y >= Y0 - BRD) && (w_y < Y0 + GLYPH_H + BRD);
    w_in_inner  = (w_x >= w_first_x) && (w_x < w_last_x + GLYPH_W) && w_in_row;

    w_vis_glyph  = w_glyph_hit && (w_state != IDLE);
    w_vis_border = w_in_outer && !w_in_inner && (w_state == EDIT) && w_blink;
  end

  logic [5:0] r_font_addr;
  logic [2:0] r_font_h, r_font_v;
  logic       r_t1_glyph, r_t1_border, r_t1_valid;
  logic       r_t2_glyph, r_t2_border, r_t2_valid;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_font_addr <= '0;
      r_font_h    <= '0;
      r_font_v    <= '0;
      r_t1_glyph  <= 1'b0;
      r_t1_border <= 1'b0;
      r_t1_valid  <= 1'b0;
      r_t2_glyph  <= 1'b0;
      r_t2_border <= 1'b0;
      r_t2_valid  <= 1'b0;
    end else begin
      r_font_addr <= w_vis_glyph ? 6'(w_code) + 6'(LETTER_BASE) : '0;
      r_font_h    <= w_vis_glyph ? 3'(w_dx >> SCALE_SHIFT) : '0;
      r_font_v    <= w_vis_glyph ? 3'(w_dy >> SCALE_SHIFT) : '0;
      r_t1_glyph  <= w_vis_glyph;
      r_t1_border <= w_vis_border;
      r_t1_valid  <= w_vis_glyph || w_vis_border;
      // Tag delayed to line up with the ROM's one-cycle read.
      r_t2_glyph  <= r_t1_glyph;
      r_t2_border <= r_t1_border;
      r_t2_valid  <= r_t1_valid;
    end
  end

  always_comb begin
    bus.o_pixel_out = 12'h000;
    if (r_t2_border) begin
      bus.o_pixel_out = COLOR_WHITE;
    end else if (r_t2_glyph) begin
      bus.o_pixel_out = bus.i_font_pixel;
    end
  end

  assign bus.o_valid     = r_t2_valid;
  assign bus.o_font_addr = r_font_addr;
  assign bus.o_font_h    = r_font_h;
  assign bus.o_font_v    = r_font_v;
  assign bus.o_name_out  = w_name;
  assign bus.o_name_done = w_name_done;

endmodule

// File: tb/tb_name_entry_renderer.sv
// Scenario bench for name_entry_renderer: FSM checks inline, pixel stream via a scoreboard
// whose ROM model returns {addr, h, v} so each glyph pixel identifies its own lookup.
module tb_name_entry_renderer;
  import game_pkg::*;

  localparam int NC = 3;
  localparam int BL = 0, BR = 1, BU = 2, BD = 3, BC = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  name_entry_renderer_if #(.NUM_CHARS(NC)) bus ();

  name_entry_renderer #(
    .NUM_CHARS    (NC),
    .SCALE_SHIFT  (4),
    .NAME_X0      (190),
    .NAME_Y0      (38),
    .CHAR_PITCH   (90),
    .BORDER       (10),
    .BLINK_FRAMES (2),
    .LETTER_BASE  (10)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always @(posedge clk) bus.i_font_pixel <= {bus.o_font_addr, bus.o_font_h, bus.o_font_v};

  typedef struct {
    int unsigned due;
    logic        ev;
    logic [11:0] ep;
    int          h;
    int          v;
  } px_t;

  px_t         sb[$];
  px_t         mon_e;
  int unsigned cyc = 0;
  int          n_checks = 0;
  int          n_fail = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #2;
    while (sb.size() > 0 && sb[0].due <= cyc) begin
      mon_e = sb.pop_front();
      n_checks++;
      if (bus.o_valid !== mon_e.ev || (mon_e.ev && bus.o_pixel_out !== mon_e.ep)) begin
        n_fail++;
        $display("FAIL pixel(%0d,%0d): valid=%b pixel=%h, required valid=%b pixel=%h",
                 mon_e.h, mon_e.v, bus.o_valid, bus.o_pixel_out, mon_e.ev, mon_e.ep);
      end
    end
  end

  function automatic logic [11:0] gp(input int a, input int h, input int v);
    return {6'(a), 3'(h), 3'(v)};
  endfunction

  task automatic put_px(input int h, input int v, input logic ev, input logic [11:0] ep);
    px_t e;
    @(posedge clk); #1;
    bus.i_h_cnt = 10'(h);
    bus.i_v_cnt = 10'(v);
    e.due = cyc + 2; e.ev = ev; e.ep = ep; e.h = h; e.v = v;
    sb.push_back(e);
  endtask

  task automatic drain();
    @(posedge clk); #1;
    bus.i_h_cnt = '0;
    bus.i_v_cnt = '0;
    for (int i = 0; i < 20 && sb.size() > 0; i++) @(posedge clk);
    #3;
    if (sb.size() != 0) begin
      n_checks++; n_fail++;
      $display("FAIL drain: %0d pixels still pending, required 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic set_btn(input int b, input logic val);
    case (b)
      BL:      bus.i_btn_left    = val;
      BR:      bus.i_btn_right   = val;
      BU:      bus.i_btn_up      = val;
      BD:      bus.i_btn_down    = val;
      default: bus.i_btn_confirm = val;
    endcase
  endtask

  task automatic press(input int b);
    @(posedge clk); #1;
    set_btn(b, 1'b1);
    @(posedge clk); #1;
    set_btn(b, 1'b0);
  endtask

  task automatic frame();
    @(posedge clk); #1;
    bus.i_frame_start = 1'b1;
    @(posedge clk); #1;
    bus.i_frame_start = 1'b0;
  endtask

  task automatic test_reset();
    bus.i_enable = 0; bus.i_btn_left = 0; bus.i_btn_right = 0; bus.i_btn_up = 0;
    bus.i_btn_down = 0; bus.i_btn_confirm = 0; bus.i_frame_start = 0;
    bus.i_h_cnt = '0; bus.i_v_cnt = '0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    n_checks++;
    if ({bus.o_name_out, bus.o_name_done, bus.o_valid, bus.o_pixel_out,
         bus.o_font_addr, bus.o_font_h, bus.o_font_v} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: name=%h done=%b valid=%b pix=%h addr=%0d, required all 0",
               bus.o_name_out, bus.o_name_done, bus.o_valid, bus.o_pixel_out, bus.o_font_addr);
    end
    repeat (3) frame();
    put_px(190, 38, 0, 12'h000);
    put_px(180, 28, 0, 12'h000);
    drain();
    bus.i_enable = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (bus.o_name_out !== 15'h0000) begin
      n_fail++; $display("FAIL enable_name: name=%h, required 0000", bus.o_name_out);
    end
    put_px(180, 28, 1, COLOR_WHITE);
    put_px(279, 159, 1, COLOR_WHITE);
    put_px(189, 100, 1, COLOR_WHITE);
    put_px(270, 100, 1, COLOR_WHITE);
    put_px(179, 100, 0, 12'h000);
    put_px(190, 160, 0, 12'h000);
    put_px(190, 38, 1, gp(10, 0, 0));
    put_px(230, 100, 1, gp(10, 2, 3));
    put_px(269, 149, 1, gp(10, 4, 6));
    put_px(280, 100, 1, gp(10, 0, 3));
    drain();
  endtask

  task automatic test_letters();
    press(BD);
    n_checks++;
    if (bus.o_name_out[14:10] !== 5'd25) begin
      n_fail++; $display("FAIL down_wrap: letter0=%0d, required 25", bus.o_name_out[14:10]);
    end
    press(BU);
    n_checks++;
    if (bus.o_name_out[14:10] !== 5'd0) begin
      n_fail++; $display("FAIL up_wrap: letter0=%0d, required 0", bus.o_name_out[14:10]);
    end
    press(BU);
    n_checks++;
    if (bus.o_name_out !== 15'h0400) begin
      n_fail++; $display("FAIL up_once: name=%h, required 0400", bus.o_name_out);
    end
    @(posedge clk); #1;
    bus.i_h_cnt = 10'd190; bus.i_v_cnt = 10'd38;
    @(posedge clk); #1;
    n_checks++;
    if (bus.o_font_addr !== 6'd11 || bus.o_font_h !== 3'd0 || bus.o_font_v !== 3'd0) begin
      n_fail++;
      $display("FAIL font_req: addr=%0d h=%0d v=%0d, required 11 0 0",
               bus.o_font_addr, bus.o_font_h, bus.o_font_v);
    end
    put_px(190, 38, 1, gp(11, 0, 0));
    drain();
  endtask

  task automatic test_cursor();
    press(BL);
    put_px(185, 100, 1, COLOR_WHITE);
    put_px(275, 100, 1, COLOR_WHITE);
    drain();
    repeat (5) press(BR);
    put_px(180, 28, 1, COLOR_WHITE);
    put_px(459, 159, 1, COLOR_WHITE);
    put_px(460, 100, 0, 12'h000);
    put_px(455, 100, 1, COLOR_WHITE);
    put_px(275, 100, 0, 12'h000);
    put_px(190, 38, 1, gp(11, 0, 0));
    put_px(370, 38, 1, gp(10, 0, 0));
    drain();
    press(BU);
    n_checks++;
    if (bus.o_name_out !== 15'h0400) begin
      n_fail++; $display("FAIL up_on_done_slot: name=%h, required 0400", bus.o_name_out);
    end
  endtask

  task automatic test_confirm();
    press(BL);
    press(BL);
    @(posedge clk); #1;
    bus.i_btn_confirm = 1'b1; bus.i_btn_up = 1'b1;
    @(posedge clk); #1;
    bus.i_btn_confirm = 1'b0; bus.i_btn_up = 1'b0;
    n_checks++;
    if (bus.o_name_out !== 15'h0400) begin
      n_fail++; $display("FAIL confirm_priority: name=%h, required 0400", bus.o_name_out);
    end
    put_px(365, 100, 1, COLOR_WHITE);
    put_px(275, 100, 0, 12'h000);
    drain();
    press(BU);
    n_checks++;
    if (bus.o_name_out !== 15'h0401) begin
      n_fail++; $display("FAIL cursor2_up: name=%h, required 0401", bus.o_name_out);
    end
    press(BC);
    @(posedge clk); #1;
    bus.i_btn_confirm = 1'b1;
    n_checks++;
    if (bus.o_name_done !== 1'b0) begin
      n_fail++; $display("FAIL done_early: name_done=%b, required 0", bus.o_name_done);
    end
    @(posedge clk); #1;
    bus.i_btn_confirm = 1'b0;
    n_checks++;
    if (bus.o_name_done !== 1'b1) begin
      n_fail++; $display("FAIL done_set: name_done=%b, required 1", bus.o_name_done);
    end
    press(BD);
    press(BL);
    press(BC);
    n_checks++;
    if (bus.o_name_out !== 15'h0401 || bus.o_name_done !== 1'b1) begin
      n_fail++;
      $display("FAIL done_sticky: name=%h done=%b, required 0401 1",
               bus.o_name_out, bus.o_name_done);
    end
    put_px(180, 28, 0, 12'h000);
    put_px(190, 38, 1, gp(11, 0, 0));
    put_px(370, 38, 1, gp(11, 0, 0));
    drain();
    @(posedge clk); #1;
    bus.i_enable = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if (bus.o_name_done !== 1'b0) begin
      n_fail++; $display("FAIL done_clear: name_done=%b, required 0", bus.o_name_done);
    end
    put_px(190, 38, 0, 12'h000);
    drain();
  endtask

  task automatic test_latency();
    @(posedge clk); #1;
    bus.i_enable = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    bus.i_h_cnt = 10'd190; bus.i_v_cnt = 10'd38;
    @(posedge clk); #1;
    bus.i_h_cnt = '0; bus.i_v_cnt = '0;
    n_checks++;
    if (bus.o_valid !== 1'b0) begin
      n_fail++; $display("FAIL latency_n1: valid=%b, required 0", bus.o_valid);
    end
    @(posedge clk); #1;
    n_checks++;
    if (bus.o_valid !== 1'b1 || bus.o_pixel_out !== gp(11, 0, 0)) begin
      n_fail++;
      $display("FAIL latency_n2: valid=%b pix=%h, required 1 %h",
               bus.o_valid, bus.o_pixel_out, gp(11, 0, 0));
    end
    @(posedge clk); #1;
    n_checks++;
    if (bus.o_valid !== 1'b0) begin
      n_fail++; $display("FAIL latency_n3: valid=%b, required 0", bus.o_valid);
    end
    for (int h = 185; h <= 195; h++) begin
      put_px(h, 100, 1, (h < 190) ? COLOR_WHITE : gp(11, 0, 3));
    end
    put_px(455, 100, 1, COLOR_WHITE);
    drain();
  endtask

  task automatic test_blink();
    logic on;
    @(posedge clk); #1;
    bus.i_enable = 1'b0;
    @(posedge clk); #1;
    bus.i_enable = 1'b1;
    @(posedge clk); #1;
    for (int f = 0; f < 6; f++) begin
      if (f > 0) frame();
`ifdef NAME_ENTRY_BLINK_EN
      on = ((f / 2) % 2) == 0;
`else
      on = 1'b1;
`endif
      put_px(180, 28, on, COLOR_WHITE);
      put_px(190, 38, 1, gp(11, 0, 0));
      drain();
    end
  endtask

  task automatic test_reset_priority();
    press(BL);
    @(posedge clk); #1;
    rst_n = 1'b0; bus.i_btn_up = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b1; bus.i_btn_up = 1'b0;
    n_checks++;
    if (bus.o_name_out !== 15'h0000 || bus.o_name_done !== 1'b0 || bus.o_valid !== 1'b0 ||
        bus.o_font_addr !== 6'd0) begin
      n_fail++;
      $display("FAIL reset_wins: name=%h done=%b valid=%b addr=%0d, required 0000 0 0 0",
               bus.o_name_out, bus.o_name_done, bus.o_valid, bus.o_font_addr);
    end
  endtask

  initial begin
    test_reset();
    test_letters();
    test_cursor();
    test_confirm();
    test_latency();
    test_blink();
    test_reset_priority();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
